// File: rtl/operand_entry.sv
// Keypad operand-capture engine: collects decimal operands digit by digit,
// converts each to saturating binary with fixed latency and presents a bundle.
module operand_entry #(
  parameter int         MAX_DIGITS = 4,
  parameter int         N_OPERANDS = 2,
  parameter int         WIDTH      = 16,
  parameter logic [3:0] KEY_ENTER  = 4'hB,
  parameter logic [3:0] KEY_DELETE = 4'hC
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3:0]                      key,
  input  logic                            key_valid,
  input  logic                            ack,
  output logic [4*MAX_DIGITS-1:0]         disp_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0] disp_count,
  output logic [$clog2(N_OPERANDS):0]     op_idx,
  output logic [N_OPERANDS*WIDTH-1:0]     operands,
  output logic [N_OPERANDS-1:0]           op_ovf,
  output logic                            ops_valid,
  output logic                            busy,
  output logic                            key_drop
);

  localparam int CNT_W = $clog2(MAX_DIGITS+1);
  localparam int IDX_W = $clog2(N_OPERANDS)+1;
  localparam int BCD_W = 4*MAX_DIGITS;
  localparam int ACC_W = WIDTH+4;

  typedef enum logic [1:0] {ENTRY, CONVERT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [BCD_W-1:0]          bcd_q, bcd_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CNT_W-1:0]          slot_q, slot_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_OPERANDS*WIDTH-1:0] ops_q, ops_d;
  logic [N_OPERANDS-1:0]     ovf_q, ovf_d;
  logic [WIDTH-1:0]          acc_q, acc_d;
  logic                      sat_q, sat_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic                      drop_q, drop_d;

  logic [3:0]                digit;
  logic [BCD_W-1:0]          key_ext;
  logic [ACC_W-1:0]          horner;
  logic                      step_ovf;
  logic                      last_slot;
  logic                      last_op;

  // Digit for the current Horner slot, most significant slot first.
  always_comb begin
    digit = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (slot_q == CNT_W'(i)) digit = bcd_q[4*(MAX_DIGITS-1-i) +: 4];
    end
  end

  // acc*10+9 never exceeds WIDTH+4 bits because acc is clamped each step.
  assign horner    = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(digit);
  assign step_ovf  = horner > ACC_W'({WIDTH{1'b1}});
  assign last_slot = slot_q == CNT_W'(MAX_DIGITS-1);
  assign last_op   = idx_q == IDX_W'(N_OPERANDS-1);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    ovf_d   = ovf_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    drop_d  = 1'b0;
    key_ext = '0;
    key_ext[3:0] = key;

    case (state_q)
      ENTRY: begin
        if (key_valid) begin
          if (key == KEY_ENTER) begin
            state_d = CONVERT;
            busy_d  = 1'b1;
            slot_d  = '0;
            acc_d   = '0;
            sat_d   = 1'b0;
          end else if (key == KEY_DELETE) begin
            if (count_q != '0) begin
              bcd_d   = bcd_q >> 4;
              count_d = count_q - CNT_W'(1);
            end else begin
              drop_d = 1'b1;
            end
          end else if (key <= 4'd9) begin
            if (count_q != CNT_W'(MAX_DIGITS)) begin
              bcd_d   = (bcd_q << 4) | key_ext;
              count_d = count_q + CNT_W'(1);
            end else begin
              drop_d = 1'b1;
            end
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      CONVERT: begin
        drop_d = key_valid;
        acc_d  = step_ovf ? {WIDTH{1'b1}} : horner[WIDTH-1:0];
        sat_d  = sat_q | step_ovf;
        slot_d = slot_q + CNT_W'(1);
        if (last_slot) begin
          for (int i = 0; i < N_OPERANDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              ops_d[i*WIDTH +: WIDTH] = acc_d;
              ovf_d[i]                = sat_d;
            end
          end
          bcd_d   = '0;
          count_d = '0;
          busy_d  = 1'b0;
          idx_d   = idx_q + IDX_W'(1);
          if (last_op) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            state_d = ENTRY;
          end
        end
      end

      DONE: begin
        // ack and an enter strobe together are one release, never a drop.
        if (ack || (key_valid && key == KEY_ENTER)) begin
          ops_d   = '0;
          ovf_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          state_d = ENTRY;
        end else if (key_valid) begin
          drop_d = 1'b1;
        end
      end

      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENTRY;
      bcd_q   <= '0;
      count_q <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      ops_q   <= '0;
      ovf_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign disp_bcd   = bcd_q;
  assign disp_count = count_q;
  assign op_idx     = idx_q;
  assign operands   = ops_q;
  assign op_ovf     = ovf_q;
  assign ops_valid  = valid_q;
  assign busy       = busy_q;
  assign key_drop   = drop_q;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: a digit-list model predicts every strobe,
// conversion and release; a monitor checks them as the DUT presents them.
module tb_operand_entry;

  localparam int         MD = 4;
  localparam int         NO = 2;
  localparam int         W  = 8;
  localparam logic [3:0] KE = 4'hB;
  localparam logic [3:0] KD = 4'hC;
  localparam int         MAXV = (1 << W) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [3:0]            key = '0;
  logic                  key_valid = 1'b0;
  logic                  ack = 1'b0;
  logic [4*MD-1:0]       disp_bcd;
  logic [$clog2(MD+1)-1:0] disp_count;
  logic [$clog2(NO):0]   op_idx;
  logic [NO*W-1:0]       operands;
  logic [NO-1:0]         op_ovf;
  logic                  ops_valid;
  logic                  busy;
  logic                  key_drop;

  operand_entry #(.MAX_DIGITS(MD), .N_OPERANDS(NO), .WIDTH(W),
                  .KEY_ENTER(KE), .KEY_DELETE(KD)) dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid), .ack(ack),
    .disp_bcd(disp_bcd), .disp_count(disp_count), .op_idx(op_idx),
    .operands(operands), .op_ovf(op_ovf), .ops_valid(ops_valid),
    .busy(busy), .key_drop(key_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              drop;
    bit              chk;
    logic [4*MD-1:0] bcd;
    int              cnt;
  } strobe_t;

  typedef struct {
    int              start;
    int              fin;
    int              idx;
    int              val;
    bit              ovf;
    bit              last;
    logic [NO*W-1:0] ops;
    logic [NO-1:0]   ovfv;
  } conv_t;

  strobe_t strobe_q[$];
  conv_t   conv_q[$];
  int      rel_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the operand being typed is just a list of digits.
  int phase = 0;
  int digs[$];
  int m_idx = 0;
  int conv_left = 0;
  int m_ops[NO];
  bit m_ovf[NO];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportMissing(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: DUT event with no expected record (cycle %0d)", name, cyc);
  endtask

  function automatic logic [4*MD-1:0] bcdOf();
    logic [4*MD-1:0] b = '0;
    foreach (digs[i]) b = (b << 4) | (4*MD)'(digs[i]);
    return b;
  endfunction

  function automatic void modelReset();
    phase = 0;
    digs.delete();
    m_idx = 0;
    conv_left = 0;
    for (int i = 0; i < NO; i++) begin
      m_ops[i] = 0;
      m_ovf[i] = 1'b0;
    end
    conv_q.delete();
    rel_q.delete();
    strobe_q.delete();
  endfunction

  task automatic applyStimulus(input bit kv, input logic [3:0] k, input bit a);
    int      e;
    int      v;
    strobe_t s;
    conv_t   c;
    @(negedge clk);
    key_valid = kv;
    key       = k;
    ack       = a;
    e = cyc + 1;
    @(posedge clk);
    s.drop = 1'b0;
    s.chk  = 1'b0;
    s.bcd  = '0;
    s.cnt  = 0;
    case (phase)
      0: if (kv) begin
        if (k == KE) begin
          v = 0;
          foreach (digs[i]) v = v * 10 + digs[i];
          m_ovf[m_idx] = v > MAXV;
          m_ops[m_idx] = (v > MAXV) ? MAXV : v;
          c.start = e;
          c.fin   = e + MD;
          c.idx   = m_idx;
          c.val   = m_ops[m_idx];
          c.ovf   = m_ovf[m_idx];
          c.last  = (m_idx == NO - 1);
          for (int i = 0; i < NO; i++) begin
            c.ops[i*W +: W] = W'(m_ops[i]);
            c.ovfv[i]       = m_ovf[i];
          end
          conv_q.push_back(c);
          phase = 1;
          conv_left = MD;
        end else if (k == KD) begin
          if (digs.size() > 0) void'(digs.pop_back());
          else s.drop = 1'b1;
        end else if (k <= 4'd9) begin
          if (digs.size() < MD) digs.push_back(int'(k));
          else s.drop = 1'b1;
        end else begin
          s.drop = 1'b1;
        end
        s.chk = 1'b1;
        s.bcd = bcdOf();
        s.cnt = digs.size();
      end
      1: begin
        if (kv) s.drop = 1'b1;
        conv_left--;
        if (conv_left == 0) begin
          digs.delete();
          m_idx++;
          phase = (m_idx == NO) ? 2 : 0;
        end
      end
      default: begin
        if (a || (kv && k == KE)) begin
          phase = 0;
          m_idx = 0;
          for (int i = 0; i < NO; i++) begin
            m_ops[i] = 0;
            m_ovf[i] = 1'b0;
          end
          rel_q.push_back(e);
        end else if (kv) begin
          s.drop = 1'b1;
        end
      end
    endcase
    if (kv) strobe_q.push_back(s);
  endtask

  task automatic pressKey(input logic [3:0] k);
    applyStimulus(1'b1, k, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_disp_bcd"}, disp_bcd, 0);
    checkOutput({tag, "_disp_count"}, disp_count, 0);
    checkOutput({tag, "_op_idx"}, op_idx, 0);
    checkOutput({tag, "_operands"}, operands, 0);
    checkOutput({tag, "_op_ovf"}, op_ovf, 0);
    checkOutput({tag, "_ops_valid"}, ops_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_key_drop"}, key_drop, 0);
  endtask

  // Monitor: pops expectations only when the DUT shows the matching event.
  initial begin
    bit      seen;
    bit      fell;
    bit      pb = 1'b0;
    bit      pv = 1'b0;
    strobe_t s;
    conv_t   c;
    int      r;
    forever begin
      @(posedge clk);
      seen = key_valid && rst;
      @(negedge clk);
      if (!rst) begin
        pb = 1'b0;
        pv = 1'b0;
      end else begin
        if (seen) begin
          if (strobe_q.size() == 0) reportMissing("strobe");
          else begin
            s = strobe_q.pop_front();
            checkOutput("key_drop", key_drop, s.drop);
            if (s.chk) begin
              checkOutput("disp_bcd", disp_bcd, s.bcd);
              checkOutput("disp_count", disp_count, s.cnt);
            end
          end
        end else begin
          checkOutput("key_drop_quiet", key_drop, 0);
        end
        if (busy && !pb) begin
          if (conv_q.size() == 0) reportMissing("busy_rise");
          else checkOutput("busy_rise_cycle", cyc, conv_q[0].start);
        end
        fell = !busy && pb;
        if (fell) begin
          if (conv_q.size() == 0) reportMissing("busy_fall");
          else begin
            c = conv_q.pop_front();
            checkOutput("busy_fall_cycle", cyc, c.fin);
            checkOutput("operand", operands[c.idx*W +: W], c.val);
            checkOutput("op_ovf", op_ovf[c.idx], c.ovf);
            checkOutput("disp_cleared", disp_count, 0);
            if (c.last) begin
              checkOutput("ops_valid_rise", ops_valid, 1);
              checkOutput("bundle", operands, c.ops);
              checkOutput("bundle_ovf", op_ovf, c.ovfv);
            end else begin
              checkOutput("op_idx_next", op_idx, c.idx + 1);
            end
          end
        end
        if (ops_valid && !pv && !fell) reportMissing("ops_valid_rise");
        if (!ops_valid && pv) begin
          if (rel_q.size() == 0) reportMissing("ops_valid_fall");
          else begin
            r = rel_q.pop_front();
            checkOutput("release_cycle", cyc, r);
            checkOutput("release_operands", operands, 0);
            checkOutput("release_ovf", op_ovf, 0);
            checkOutput("release_op_idx", op_idx, 0);
          end
        end
        pb = busy;
        pv = ops_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          r;
    logic [3:0]  k;
    modelReset();
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    #2 rst = 1'b1;

    // 123, 45 bundle, then ack.
    pressKey(4'd1); pressKey(4'd2); pressKey(4'd3); pressKey(KE); idle(4);
    pressKey(4'd4); pressKey(4'd5); pressKey(KE); idle(5);
    applyStimulus(1'b0, 4'h0, 1'b1); idle(2);

    // Delete behaviour, including delete on an empty entry.
    pressKey(4'd9); pressKey(4'd8); pressKey(KD); pressKey(4'd7); pressKey(KE); idle(4);
    pressKey(KD); pressKey(4'hA); pressKey(4'd1); pressKey(KE); idle(5);
    applyStimulus(1'b0, 4'h0, 1'b1);

    // Fifth digit dropped; saturation at WIDTH=8.
    pressKey(4'd1); pressKey(4'd2); pressKey(4'd3); pressKey(4'd4); pressKey(4'd5);
    pressKey(KE); idle(4);
    pressKey(4'd9); pressKey(4'd9); pressKey(4'd9); pressKey(KE); idle(5);
    applyStimulus(1'b0, 4'h0, 1'b1);
    pressKey(4'd9); pressKey(4'd9); pressKey(4'd9); pressKey(KE); idle(4);
    pressKey(4'd2); pressKey(4'd5); pressKey(4'd5); pressKey(KE); idle(5);
    pressKey(4'd3); pressKey(KE); idle(1);

    // Empty operands; digit in DONE dropped; ack with a key is one release.
    pressKey(KE); idle(4); pressKey(KE); idle(5);
    pressKey(4'd6);
    applyStimulus(1'b1, 4'd6, 1'b1); idle(1);
    checkOutput("after_ack_op_idx", op_idx, 0);

    // Key lost during conversion, then reset mid-conversion.
    pressKey(4'd4); pressKey(KE); idle(1); pressKey(4'd7); idle(3);
    pressKey(4'd5); pressKey(KE); idle(1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkAllZero("midreset");
    modelReset();
    @(negedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      k = 4'($urandom_range(0, 9));
      else if (r < 75) k = KE;
      else if (r < 90) k = KD;
      else begin
        r = $urandom_range(0, 3);
        k = (r == 0) ? 4'hA : 4'(r + 12);
      end
      applyStimulus($urandom_range(0, 1) == 1, k, $urandom_range(0, 9) == 0);
    end

    idle(MD + 4);
    checkOutput("pending_strobes", strobe_q.size(), 0);
    checkOutput("pending_conversions", conv_q.size(), 0);
    checkOutput("pending_releases", rel_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
